// File: rtl/compress7_3.sv
// compress7_3: 7-input ones counter built as a carry-save tree, with an optional registered copy.
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   in        7 operand bits to count
//   in_valid  qualifies in for the registered path
//   out       combinational count of ones in in (0..7)
//   out_q     registered count, loaded when in_valid is high
//   out_valid high for the cycle after a captured in_valid
//   err       sticky tree-vs-reference mismatch flag
// Optional feature: define COMPRESS7_3_SELFCHECK_EN to build the self-check comparator;
// otherwise err is tied low.
module compress7_3 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] in,
    input  logic       in_valid,
    output logic [2:0] out,
    output logic [2:0] out_q,
    output logic       out_valid,
    output logic       err
);
    function automatic logic [1:0] fa(input logic a, input logic b, input logic c);
        return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction
    logic [1:0] fa0, fa1, fa2, fa3;
    always_comb begin
        fa0 = fa(in[0], in[1], in[2]);
        fa1 = fa(in[3], in[4], in[5]);
        fa2 = fa(fa0[0], fa1[0], in[6]);
        fa3 = fa(fa0[1], fa1[1], fa2[1]);
        out = {fa3[1], fa3[0], fa2[0]};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q     <= 3'b000;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) out_q <= out;
        end
    end
`ifdef COMPRESS7_3_SELFCHECK_EN
    // Reference is a plain bit-by-bit sum, independent of the adder tree above.
    logic [2:0] ref_sum;
    logic       err_q;
    always_comb begin
        ref_sum = 3'b000;
        for (int i = 0; i < 7; i++) ref_sum = ref_sum + {2'b00, in[i]};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else if (in_valid && (out != ref_sum)) err_q <= 1'b1;
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_compress7_3.sv
// tb_compress7_3: directed self-checking bench for compress7_3 with a popcount reference model.
module tb_compress7_3;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] in = 7'h00;
    logic       in_valid = 1'b0;
    logic [2:0] out, out_q;
    logic       out_valid, err;
    int total = 0;
    int bad = 0;
    logic [2:0] mq = 3'd0;
    logic       mv = 1'b0;

    compress7_3 dut (
        .clk(clk), .rst_n(rst_n), .in(in), .in_valid(in_valid),
        .out(out), .out_q(out_q), .out_valid(out_valid), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sum_bits(input logic [6:0] v);
        int s = 0;
        for (int i = 0; i < 7; i++) s += int'(v[i]);
        return s;
    endfunction

    // Reference behaviour: capture the ones count when valid, drop valid otherwise.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq = 3'd0;
            mv = 1'b0;
        end else begin
            mv = in_valid;
            if (in_valid) mq = 3'($countones(in));
        end
    end

    always @(negedge clk) begin
        chk("model_out", int'(out), $countones(in));
        chk("model_out_q", int'(out_q), int'(mq));
        chk("model_out_valid", int'(out_valid), int'(mv));
        chk("model_err", int'(err), 0);
    end

    task automatic drive(input logic [6:0] v, input logic val);
        @(posedge clk);
        #2;
        in = v;
        in_valid = val;
    endtask

    initial begin
        #3;
        chk("reset_out_q", int'(out_q), 0);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_err", int'(err), 0);
        #14 rst_n = 1'b1;

        // Single valid input then an idle cycle.
        drive(7'h7F, 1'b1);
        drive(7'h00, 1'b0);
        @(negedge clk);
        chk("single_q", int'(out_q), 7);
        chk("single_v", int'(out_valid), 1);
        drive(7'h00, 1'b0);
        @(negedge clk);
        chk("single_hold_q", int'(out_q), 7);
        chk("single_hold_v", int'(out_valid), 0);

        // Back-to-back stream.
        drive(7'h01, 1'b1);
        drive(7'h03, 1'b1);
        @(negedge clk);
        chk("stream_q1", int'(out_q), 1);
        chk("stream_v1", int'(out_valid), 1);
        drive(7'h07, 1'b1);
        @(negedge clk);
        chk("stream_q2", int'(out_q), 2);
        chk("stream_v2", int'(out_valid), 1);
        drive(7'h00, 1'b0);
        @(negedge clk);
        chk("stream_q3", int'(out_q), 3);
        chk("stream_v3", int'(out_valid), 1);

        // Full sweep with in_valid high, 10 ns per value.
        for (int i = 0; i < 128; i++) begin
            drive(7'(i), 1'b1);
            #1;
            chk("sweep_out", int'(out), sum_bits(7'(i)));
            if (i == 8'h00) chk("spot_00", int'(out), 0);
            if (i == 8'h7F) chk("spot_7f", int'(out), 7);
            if (i == 8'h55) chk("spot_55", int'(out), 4);
            if (i == 8'h2A) chk("spot_2a", int'(out), 3);
        end
        drive(7'h00, 1'b0);
        chk("sweep_err", int'(err), 0);

        // Asynchronous reset between edges while a result is valid.
        drive(7'h1F, 1'b1);
        @(posedge clk);
        #3;
        chk("pre_rst_q", int'(out_q), 5);
        chk("pre_rst_v", int'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_q", int'(out_q), 0);
        chk("async_rst_v", int'(out_valid), 0);
        chk("async_rst_err", int'(err), 0);
        chk("rst_out_unaffected", int'(out), 5);
        in_valid = 1'b0;
        #3 rst_n = 1'b1;

        // First capture after reset release.
        drive(7'h55, 1'b1);
        drive(7'h00, 1'b0);
        @(negedge clk);
        chk("post_rst_q", int'(out_q), 4);
        chk("post_rst_v", int'(out_valid), 1);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/compress7_3.md
COMPRESS7_3 -- requirements
Module: compress7_3

Interface
- No parameters; all widths fixed.
- REQ-001: The block SHALL have one clock and an asynchronous, active-low reset: `clk` (input, 1, rising-edge clock) and `rst_n` (input, 1, asynchronous active-low reset).
- REQ-002: `in` SHALL be input, 7 bits, the operand bits to be counted.
- REQ-003: `in_valid` SHALL be input, 1 bit, qualifying `in` for the registered path.
- REQ-004: `out` SHALL be output, 3 bits, the combinational count of ones in `in`.
- REQ-005: `out_q` SHALL be output, 3 bits, the registered count.
- REQ-006: `out_valid` SHALL be output, 1 bit, qualifying `out_q`.
- REQ-007: `err` SHALL be output, 1 bit, the sticky self-check error flag (see Configuration).

Function
- REQ-008: `out` SHALL equal in[0]+in[1]+…+in[6], as an unsigned value from 0 to 7, purely combinationally with zero cycle latency and no dependence on `clk`, `rst_n` or `in_valid`.
- REQ-009: `out` SHALL be built as a carry-save tree:
  - two full adders on {in[0],in[1],in[2]} and {in[3],in[4],in[5]};
  - a third full adder on the two sum bits plus in[6], giving bit 0;
  - a fourth full adder on the three carries, giving bit 1 (sum) and bit 2 (carry).
- REQ-010: No overflow SHALL be possible: the maximum count of 7 SHALL give out=3'b111, and 0 SHALL give 3'b000.
- REQ-011: On each rising `clk` edge with in_valid=1, `out_q` SHALL load the current `out` and `out_valid` SHALL be 1 in the following cycle (1-cycle latency).
- REQ-012: On a rising edge with in_valid=0, `out_q` SHALL hold its value and `out_valid` SHALL go to 0.
- REQ-013: Back-to-back valid inputs SHALL produce back-to-back valid outputs, with no bubbles and no backpressure.
- REQ-014: X on any `in` bit SHALL NOT be masked; the bench treats it as illegal stimulus.

Reset
- REQ-015: While rst_n=0, `out_q` SHALL be 3'b000, `out_valid` SHALL be 0 and `err` SHALL be 0, asynchronously and without waiting for `clk`.
- REQ-016: Reset asserted mid-stream SHALL discard any pending result.
- REQ-017: The first capture after reset SHALL occur on the first rising edge after rst_n deasserts with in_valid=1.
- REQ-018: `out` SHALL be unaffected by reset.

Configuration
- REQ-019: Macro COMPRESS7_3_SELFCHECK_EN SHALL control the self-check feature.
  - Defined: each cycle with in_valid=1, the tree result SHALL be compared against an independent behavioural sum of the seven bits. A mismatch SHALL set `err`=1 on the next edge, and `err` SHALL stay set until reset.
  - Undefined: `err` SHALL be tied to 0 and no comparator logic SHALL be synthesised.
  - The port list SHALL be identical in both builds.

Verification
- REQ-020: Exhaustive combinational sweep: in = 0..127 with a 10 ns hold each -> `out` equals the popcount every step. Spot values:
  - 7'h00 -> 0
  - 7'h7F -> 7
  - 7'h55 -> 4
  - 7'h2A -> 3
- REQ-021: Registered path: rst_n=0 then release, apply in=7'h7F with in_valid=1 for one cycle -> next cycle out_q=7 and out_valid=1; the cycle after, out_valid=0 and out_q still 7.
- REQ-022: Streaming: in = 7'h01, 7'h03, 7'h07 on consecutive cycles with in_valid=1 -> out_q = 1, 2, 3 on the three following cycles with out_valid continuously 1.
- REQ-023: Asynchronous reset: with out_q=5 and out_valid=1, drop rst_n between clock edges -> out_q=0, out_valid=0 and err=0 immediately.
- REQ-024: With COMPRESS7_3_SELFCHECK_EN defined, the full 128-value sweep with in_valid=1 -> err remains 0 throughout.
